uart_wb_bridge: RTL and testbench

//  Byte-stream to Wishbone master bridge. Sits between the UART byte receiver/transmitter and the
//  SoC Wishbone bus. Decodes host frames into 32-bit Wishbone read/write bursts and returns read

---
 rtl/uart_wb_bridge_pkg.sv | 22 ++
 rtl/uart_wb_bridge.sv | 171 +++++++++++++++++
 tb/tb_uart_wb_bridge.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_wb_bridge_pkg.sv
// Shared command codes and FSM state type for the UART-to-Wishbone bridge.
package uart_wb_bridge_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StAddr,
        StWdata,
        StWbWr,
        StWbRd,
        StTx
    } state_e;

    // Byte-consuming states; everywhere else the host stream is back-pressured.
    function automatic logic accepts_bytes(input state_e s);
        return s inside {StIdle, StLen, StAddr, StWdata};
    endfunction

endpackage

// File: rtl/uart_wb_bridge.sv
// Host byte-stream to 32-bit Wishbone master: CMD, LEN, ADDR (BE), then write words or read replies.
// Optional mid-frame idle timeout when UART_WB_BRIDGE_TIMEOUT_EN is defined.
module uart_wb_bridge
    import uart_wb_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 30,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  wb_cyc,
    output logic                  wb_stb,
    output logic                  wb_we,
    output logic [ADDR_WIDTH-1:0] wb_adr,
    output logic [3:0]            wb_sel,
    output logic [31:0]           wb_dat_w,
    input  logic [31:0]           wb_dat_r,
    input  logic                  wb_ack
);

    state_e                state_q, state_d;
    logic                  is_read_q, is_read_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [7:0]            words_q, words_d;
    logic [31:0]           shift_q, shift_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic                  rx_ready_q;
    logic                  rx_fire;

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TmoW-1:0] tmo_q, tmo_d;
`endif

    assign rx_fire = rx_valid && rx_ready;

    always_comb begin
        state_d    = state_q;
        is_read_d  = is_read_q;
        byte_cnt_d = byte_cnt_q;
        words_d    = words_q;
        shift_d    = shift_q;
        adr_d      = adr_q;
        unique case (state_q)
            StIdle: begin
                if (rx_fire && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
                    is_read_d = (rx_data == CMD_READ);
                    state_d   = StLen;
                end
            end
            StLen: begin
                if (rx_fire) begin
                    words_d    = rx_data;
                    byte_cnt_d = 2'd0;
                    state_d    = StAddr;
                end
            end
            StAddr: begin
                if (rx_fire) begin
                    shift_d    = {shift_q[23:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        adr_d = ADDR_WIDTH'({shift_q[23:0], rx_data});
                        if (words_q == 8'd0) begin
                            state_d = StIdle;
                        end else if (is_read_q) begin
                            state_d = StWbRd;
                        end else begin
                            state_d = StWdata;
                        end
                    end
                end
            end
            StWdata: begin
                if (rx_fire) begin
                    shift_d    = {shift_q[23:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = StWbWr;
                    end
                end
            end
            StWbWr: begin
                if (wb_ack) begin
                    words_d = words_q - 8'd1;
                    adr_d   = adr_q + ADDR_WIDTH'(1);
                    state_d = (words_q == 8'd1) ? StIdle : StWdata;
                end
            end
            StWbRd: begin
                if (wb_ack) begin
                    shift_d    = wb_dat_r;
                    words_d    = words_q - 8'd1;
                    adr_d      = adr_q + ADDR_WIDTH'(1);
                    byte_cnt_d = 2'd0;
                    state_d    = StTx;
                end
            end
            StTx: begin
                if (tx_ready) begin
                    shift_d    = {shift_q[23:0], 8'h00};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = (words_q == 8'd0) ? StIdle : StWbRd;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
        // Idle-byte counter only runs while a frame header/payload is being received.
        tmo_d = '0;
        if (state_q inside {StLen, StAddr, StWdata} && !rx_fire) begin
            if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                state_d = StIdle;
            end else begin
                tmo_d = tmo_q + TmoW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            is_read_q  <= 1'b0;
            byte_cnt_q <= 2'd0;
            words_q    <= 8'd0;
            shift_q    <= 32'd0;
            adr_q      <= '0;
            rx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_read_q  <= is_read_d;
            byte_cnt_q <= byte_cnt_d;
            words_q    <= words_d;
            shift_q    <= shift_d;
            adr_q      <= adr_d;
            // Registered so rx_ready stays low through reset and rises one cycle after.
            rx_ready_q <= accepts_bytes(state_d);
        end
    end

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign rx_ready = rx_ready_q;
    assign wb_cyc   = (state_q == StWbWr) || (state_q == StWbRd);
    assign wb_stb   = wb_cyc;
    assign wb_we    = (state_q == StWbWr);
    assign wb_adr   = adr_q;
    assign wb_sel   = wb_cyc ? 4'hF : 4'h0;
    assign wb_dat_w = shift_q;
    assign tx_valid = (state_q == StTx);
    assign tx_data  = shift_q[31:24];

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Self-checking bench for uart_wb_bridge: frame table, Wishbone slave model, tx byte sink.
`timescale 1ns/1ps
module tb_uart_wb_bridge;
    import uart_wb_bridge_pkg::*;

    localparam int unsigned AW = 30;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          wb_cyc;
    logic          wb_stb;
    logic          wb_we;
    logic [AW-1:0] wb_adr;
    logic [3:0]    wb_sel;
    logic [31:0]   wb_dat_w;
    logic [31:0]   wb_dat_r;
    logic          wb_ack;

    always #5 clk = ~clk;

    uart_wb_bridge #(
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .wb_cyc  (wb_cyc),
        .wb_stb  (wb_stb),
        .wb_we   (wb_we),
        .wb_adr  (wb_adr),
        .wb_sel  (wb_sel),
        .wb_dat_w(wb_dat_w),
        .wb_dat_r(wb_dat_r),
        .wb_ack  (wb_ack)
    );

    typedef struct {
        logic [AW-1:0] adr;
        logic          we;
        logic [31:0]   dat;
    } wb_exp_t;

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  len;
        logic [31:0] addr;
        logic [31:0] d0;
        logic [31:0] d1;
        int          ack_delay;
        int          tx_stall;
    } frame_t;

    wb_exp_t     exp_wb[$];
    logic [31:0] rd_q[$];
    logic [7:0]  exp_tx[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          ack_delay = 0;
    int          tx_stall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%h, required 0x%h", name, act, req);
    endtask

    task automatic check_reset_vals();
        check("rst_rx_ready", rx_ready, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_wb_cyc", wb_cyc, 0);
        check("rst_wb_stb", wb_stb, 0);
        check("rst_wb_we", wb_we, 0);
        check("rst_wb_adr", wb_adr, 0);
        check("rst_wb_sel", wb_sel, 0);
        check("rst_wb_dat_w", wb_dat_w, 0);
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            n_checks++;
            $display("FAIL rx_accept_timeout: rx_ready=0 after %0d cycles, required 1", n);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input frame_t f);
        logic [31:0]   w;
        logic [AW-1:0] a;
        wb_exp_t       e;
        ack_delay = f.ack_delay;
        tx_stall  = f.tx_stall;
        send_byte(f.cmd);
        if (f.cmd != CMD_WRITE && f.cmd != CMD_READ) return;
        send_byte(f.len);
        for (int i = 3; i >= 0; i--) send_byte(f.addr[8*i +: 8]);
        a = f.addr[AW-1:0];
        for (int k = 0; k < int'(f.len); k++) begin
            w     = (k == 0) ? f.d0 : f.d1;
            e.adr = a;
            e.we  = (f.cmd == CMD_WRITE);
            e.dat = e.we ? w : 32'h0;
            exp_wb.push_back(e);
            if (e.we) begin
                for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
            end else begin
                rd_q.push_back(w);
                for (int i = 3; i >= 0; i--) exp_tx.push_back(w[8*i +: 8]);
            end
            a = a + AW'(1);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_wb.size() != 0 || exp_tx.size() != 0 || !rx_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("frame_wb_left", exp_wb.size(), 0);
        check("frame_tx_left", exp_tx.size(), 0);
        check("idle_rx_ready", rx_ready, 1);
    endtask

    // Wishbone slave: holds off ack for ack_delay cycles, checks the held request.
    initial begin : wb_slave
        logic [AW-1:0] a0;
        logic [31:0]   d0;
        logic          we0;
        logic          stable;
        wb_exp_t       e;
        wb_ack   = 1'b0;
        wb_dat_r = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (wb_cyc && !rst) begin
                a0     = wb_adr;
                d0     = wb_dat_w;
                we0    = wb_we;
                stable = 1'b1;
                for (int i = 0; i < ack_delay; i++) begin
                    check("rx_ready_bus_busy", rx_ready, 0);
                    @(negedge clk);
                    #1;
                    if (wb_adr !== a0 || wb_dat_w !== d0 || wb_we !== we0 || !wb_stb || !wb_cyc)
                        stable = 1'b0;
                end
                if (ack_delay > 0) check("wb_held_stable", stable, 1);
                check("wb_stb", wb_stb, 1);
                check("wb_sel", wb_sel, 4'hF);
                check("rx_ready_bus", rx_ready, 0);
                if (exp_wb.size() == 0) begin
                    n_checks++;
                    $display("FAIL wb_unexpected: got cycle adr=0x%h we=%0b, required none",
                             wb_adr, wb_we);
                end else begin
                    e = exp_wb.pop_front();
                    check("wb_adr", wb_adr, e.adr);
                    check("wb_we", wb_we, e.we);
                    if (e.we) check("wb_dat_w", wb_dat_w, e.dat);
                    else wb_dat_r = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hBAD0BAD0;
                end
                wb_ack = 1'b1;
                @(negedge clk);
                #1;
                wb_ack = 1'b0;
                check("wb_cyc_drop", wb_cyc, 0);
            end
        end
    end

    // Transmit sink: stalls tx_ready for tx_stall cycles per byte.
    initial begin : tx_sink
        logic [7:0] b;
        logic       ok;
        tx_ready = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            tx_ready = 1'b0;
            if (tx_valid && !rst) begin
                b  = tx_data;
                ok = 1'b1;
                for (int i = 0; i < tx_stall; i++) begin
                    @(negedge clk);
                    #1;
                    if (!tx_valid || tx_data !== b) ok = 1'b0;
                end
                if (tx_stall > 0) check("tx_held_stable", ok, 1);
                check("rx_ready_tx", rx_ready, 0);
                if (exp_tx.size() == 0) begin
                    n_checks++;
                    $display("FAIL tx_unexpected: got byte 0x%h, required none", b);
                end else begin
                    check("tx_data", b, exp_tx.pop_front());
                end
                tx_ready = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        frame_t vec[9];
        frame_t f;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        vec[0] = '{CMD_WRITE, 8'd1, 32'h00002403, 32'h12345678, 32'h0, 0, 0};
        vec[1] = '{CMD_READ,  8'd2, 32'h04000000, 32'hDEADBEEF, 32'h01020304, 0, 0};
        vec[2] = '{8'h07,     8'd0, 32'h0,        32'h0,        32'h0, 0, 0};
        vec[3] = '{CMD_WRITE, 8'd1, 32'h00000010, 32'hCAFEF00D, 32'h0, 1, 0};
        vec[4] = '{CMD_WRITE, 8'd0, 32'h00000055, 32'h0,        32'h0, 0, 0};
        vec[5] = '{CMD_WRITE, 8'd2, 32'h3FFFFFFF, 32'hA5A5A5A5, 32'h5A5A5A5A, 2, 0};
        vec[6] = '{CMD_READ,  8'd1, 32'hC0000005, 32'h11223344, 32'h0, 0, 1};
        vec[7] = '{CMD_WRITE, 8'd1, 32'h00000100, 32'h89ABCDEF, 32'h0, 5, 3};
        vec[8] = '{CMD_READ,  8'd2, 32'h00000200, 32'h55AA55AA, 32'h0F0F0F0F, 5, 3};

        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        @(negedge clk);
        check("rx_ready_after_rst", rx_ready, 1);

        for (int i = 0; i < 9; i++) begin
            send_frame(vec[i]);
            wait_idle();
        end

        // Reset after the third address byte: partial frame must vanish.
        send_byte(CMD_WRITE);
        send_byte(8'd1);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h30);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        @(negedge clk);
        check("rx_ready_after_rst2", rx_ready, 1);
        f = '{CMD_WRITE, 8'd1, 32'h00000031, 32'h0BADCAFE, 32'h0, 0, 0};
        send_frame(f);
        wait_idle();

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
        send_byte(CMD_WRITE);
        send_byte(8'd1);
        repeat (105) @(negedge clk);
        f = '{CMD_WRITE, 8'd1, 32'h00000077, 32'hFEEDFACE, 32'h0, 0, 0};
        send_frame(f);
        wait_idle();
`endif

        check("final_rd_left", rd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
